// File: rtl/stream_mux_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_rr_if
// Purpose  : Bundle of the N_CH-to-1 stream multiplexer's data and handshake
//            signals. The master modport is the side that drives the input
//            channels and accepts the output stream. The slave modport is
//            the multiplexer itself.
// Revision : 1.0  initial release
// ============================================================================
interface stream_mux_rr_if #(
    parameter int N_CH   = 8,
    parameter int DATA_W = 8
);
    localparam int SEL_W = $clog2(N_CH);

    logic                   mode;
    logic [SEL_W-1:0]       sel;
    logic [N_CH-1:0]        in_valid;
    logic [N_CH*DATA_W-1:0] in_data;
    logic [N_CH-1:0]        in_ready;
    logic                   out_valid;
    logic [DATA_W-1:0]      out_data;
    logic [SEL_W-1:0]       out_ch;
    logic                   out_ready;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_rr
// Purpose  : N_CH-to-1 stream multiplexer with a one-word output register.
//            Arbitration is either round-robin over valid channels or a fixed
//            channel chosen by sel.
// Revision : 1.0  initial release
// ============================================================================
module stream_mux_rr #(
    parameter int N_CH   = 8,
    parameter int DATA_W = 8
) (
    input  wire              clk,
    input  wire              rst,
    stream_mux_rr_if.slave   bus
);
    localparam int SEL_W   = $clog2(N_CH);
    // One extra bit so that ptr + offset can exceed N_CH-1 before wrapping.
    localparam int C_IDX_W = SEL_W + 1;

    logic [SEL_W-1:0]  r_ptr;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [SEL_W-1:0]  r_out_ch;

    logic [C_IDX_W-1:0] w_idx_wide;
    logic               w_rr_found;
    logic [SEL_W-1:0]   w_rr_grant;
    logic               w_sel_ok;
    logic               w_fx_found;
    logic               w_grant_valid;
    logic [SEL_W-1:0]   w_grant;
    logic               w_load_en;
    logic               w_xfer;
    logic [N_CH-1:0]    w_in_ready;
    logic [DATA_W-1:0]  w_grant_data;
    logic [SEL_W-1:0]   w_ptr_next;

    // Round-robin search: first valid channel starting at r_ptr, wrapping.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_grant = '0;
        w_idx_wide = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_idx_wide = {1'b0, r_ptr} + C_IDX_W'(i);
            if (w_idx_wide >= C_IDX_W'(N_CH)) begin
                w_idx_wide = w_idx_wide - C_IDX_W'(N_CH);
            end
            if (!w_rr_found && bus.in_valid[w_idx_wide[SEL_W-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_grant = w_idx_wide[SEL_W-1:0];
            end
        end
    end

    // Fixed mode only grants an in-range sel whose channel is valid.
    assign w_sel_ok      = ({1'b0, bus.sel} < C_IDX_W'(N_CH));
    assign w_fx_found    = w_sel_ok && bus.in_valid[bus.sel];
    assign w_grant_valid = bus.mode ? w_fx_found : w_rr_found;
    assign w_grant       = bus.mode ? bus.sel    : w_rr_grant;

    // Register can take a word when empty or being drained this cycle.
    assign w_load_en = !r_out_valid || bus.out_ready;
    assign w_xfer    = !rst && w_load_en && w_grant_valid;

    assign w_ptr_next = (w_grant == SEL_W'(N_CH - 1)) ? '0 : w_grant + SEL_W'(1);

    // One-hot ready strobe to the granted channel only.
    always_comb begin
        w_in_ready = '0;
        if (w_xfer) begin
            w_in_ready[w_grant] = 1'b1;
        end
    end

    // Select the granted channel's data word.
    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_grant == SEL_W'(i)) begin
                w_grant_data = bus.in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Output register: load on transfer, clear valid on pop without refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_grant_data;
            r_out_ch    <= w_grant;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Round-robin pointer advances past the winner on a round-robin transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_xfer && !bus.mode) begin
            r_ptr <= w_ptr_next;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_mux_rr
// Purpose  : Self-checking bench for stream_mux_rr (N_CH=8, DATA_W=8):
//            directed scenarios with literal expectations followed by a
//            randomized run checked every cycle against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_stream_mux_rr;
    localparam int N_CH   = 8;
    localparam int DATA_W = 8;

    logic clk;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    stream_mux_rr_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

    stream_mux_rr #(.N_CH(N_CH), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_data(input logic [7:0] base);
        for (int i = 0; i < N_CH; i++) begin
            bus.in_data[i*DATA_W +: DATA_W] = base + 8'(i);
        end
    endtask

    // Behavioural model: contents of the output register and the rr pointer.
    int          m_ptr   = 0;
    logic        m_valid = 1'b0;
    logic [7:0]  m_data  = 8'h00;
    int          m_ch    = 0;
    int          m_g;
    int          m_c;
    bit          m_found;
    bit          m_accept;
    logic [7:0]  m_exp_ready;

    // Compare DUT against the model mid-cycle, then advance the model.
    always @(negedge clk) begin
        m_found = 1'b0;
        m_g     = 0;
        if (bus.mode) begin
            if (int'(bus.sel) < N_CH && bus.in_valid[bus.sel]) begin
                m_found = 1'b1;
                m_g     = int'(bus.sel);
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                m_c = (m_ptr + k) % N_CH;
                if (!m_found && bus.in_valid[m_c]) begin
                    m_found = 1'b1;
                    m_g     = m_c;
                end
            end
        end
        m_accept    = !rst && (!m_valid || bus.out_ready) && m_found;
        m_exp_ready = m_accept ? 8'(1 << m_g) : 8'h00;

        chk("model_in_ready",  32'(bus.in_ready),  32'(m_exp_ready));
        chk("model_out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("model_out_data",  32'(bus.out_data),  32'(m_data));
        chk("model_out_ch",    32'(bus.out_ch),    32'(m_ch));

        if (rst) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_ch    = 0;
            m_ptr   = 0;
        end else if (m_accept) begin
            m_valid = 1'b1;
            m_data  = bus.in_data[m_g*DATA_W +: DATA_W];
            m_ch    = m_g;
            if (!bus.mode) m_ptr = (m_g + 1) % N_CH;
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
        end
    end

    initial begin
        logic [7:0] skip_seq [3];
        skip_seq[0] = 8'd2;
        skip_seq[1] = 8'd7;
        skip_seq[2] = 8'd2;

        // Reset held two edges with every channel valid.
        rst           = 1'b1;
        bus.mode      = 1'b0;
        bus.sel       = '0;
        bus.in_valid  = 8'hFF;
        bus.out_ready = 1'b1;
        fill_data(8'hB0);
        @(negedge clk);
        @(negedge clk);
        chk("reset_in_ready",  32'(bus.in_ready),  32'h0);
        chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
        chk("reset_out_data",  32'(bus.out_data),  32'h0);
        chk("reset_out_ch",    32'(bus.out_ch),    32'h0);

        // Fixed-mode sweep, one channel at a time.
        for (int k = 0; k <= N_CH; k++) begin
            tick();
            rst      = 1'b0;
            bus.mode = 1'b1;
            fill_data(8'hA0);
            if (k < N_CH) begin
                bus.sel      = 3'(k);
                bus.in_valid = 8'(1 << k);
            end else begin
                bus.in_valid = 8'h00;
            end
            @(negedge clk);
            if (k < N_CH) chk("fixed_in_ready", 32'(bus.in_ready), 32'(1 << k));
            if (k > 0) begin
                chk("fixed_out_data", 32'(bus.out_data), 32'(8'hA0 + 8'(k - 1)));
                chk("fixed_out_ch",   32'(bus.out_ch),   32'(k - 1));
            end
        end

        // Round-robin fairness with all channels valid.
        for (int j = 0; j <= N_CH + 1; j++) begin
            tick();
            bus.mode     = 1'b0;
            bus.in_valid = 8'hFF;
            fill_data(8'hB0);
            @(negedge clk);
            if (j > 0) begin
                chk("rr_out_ch",   32'(bus.out_ch),   32'((j - 1) % N_CH));
                chk("rr_out_data", 32'(bus.out_data), 32'(8'hB0 + 8'((j - 1) % N_CH)));
            end
        end

        // Reset pulse with a word held: word discarded, pointer back to 0.
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        rst          = 1'b0;
        bus.in_valid = 8'h00;
        @(negedge clk);
        chk("midreset_out_valid", 32'(bus.out_valid), 32'h0);

        // Pointer skip over idle channels: 2, 7, 2.
        for (int j = 0; j <= 3; j++) begin
            tick();
            bus.in_valid = (j < 3) ? 8'b1000_0100 : 8'h00;
            @(negedge clk);
            if (j < 3) chk("skip_in_ready", 32'(bus.in_ready), (j == 1) ? 32'h80 : 32'h04);
            if (j > 0) chk("skip_out_ch", 32'(bus.out_ch), 32'(skip_seq[j - 1]));
        end

        // Backpressure: load ch3, stall three cycles, release.
        tick();
        bus.in_valid = 8'hFF;
        fill_data(8'hB0);
        @(negedge clk);
        chk("bp_load_in_ready", 32'(bus.in_ready), 32'h08);
        for (int j = 0; j < 3; j++) begin
            tick();
            bus.out_ready = 1'b0;
            @(negedge clk);
            chk("bp_out_valid", 32'(bus.out_valid), 32'h1);
            chk("bp_out_ch",    32'(bus.out_ch),    32'h3);
            chk("bp_out_data",  32'(bus.out_data),  32'hB3);
            chk("bp_in_ready",  32'(bus.in_ready),  32'h0);
        end
        tick();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'h10);
        tick();
        @(negedge clk);
        chk("bp_resume_out_ch",   32'(bus.out_ch),   32'h4);
        chk("bp_resume_out_data", 32'(bus.out_data), 32'hB4);

        // Fixed-mode miss: sel points at an idle channel.
        tick();
        bus.mode     = 1'b1;
        bus.sel      = 3'd3;
        bus.in_valid = 8'b0000_0100;
        @(negedge clk);
        chk("miss_in_ready",  32'(bus.in_ready),  32'h0);
        chk("miss_out_valid", 32'(bus.out_valid), 32'h1);
        tick();
        @(negedge clk);
        chk("miss_drained_valid", 32'(bus.out_valid), 32'h0);
        chk("miss_hold_ch",       32'(bus.out_ch),    32'h5);

        // Randomized traffic; the model checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
            bus.sel       = 3'($urandom_range(0, 7));
            bus.in_valid  = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom);
            bus.in_data   = 64'({$urandom, $urandom});
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
